// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the iterative multiply/divide unit.
// Op codes are also used by the instruction decoder and ALU control, so the
// numeric values must not change.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    SIGN = 2'b10,
    DONE = 2'b11
  } md_state_e;

  function automatic logic is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_signed_op(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide engine, one result bit per cycle.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   start, op, a, b   request, operation (muldiv_pkg encoding), operands
//   cancel            flush; returns to IDLE without producing a result
//   busy              operation in flight (CALC or SIGN)
//   valid             one-cycle pulse, hi/lo hold a fresh result
//   hi, lo            product high/low half, or remainder/quotient
//   div_by_zero       qualifies valid: divide issued with b == 0
//
// Datapath: a 2*WIDTH shift register (acc) and one adder shared by both ops.
// Multiply shifts right, adding the multiplicand into the upper half when the
// current multiplier bit (acc[0]) is set. Divide shifts left, trial-subtracts
// the divisor from the partial remainder and keeps the difference when it
// does not borrow; the quotient bits fill in from the bottom.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int W2    = 2 * WIDTH;

  // Two's-complement negate when n is set (modulo 2^WIDTH / 2^(2*WIDTH)).
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic n);
    return n ? ((~v) + WIDTH'(1)) : v;
  endfunction

  function automatic logic [W2-1:0] cond_neg2(input logic [W2-1:0] v,
                                              input logic n);
    return n ? ((~v) + W2'(1)) : v;
  endfunction

  md_state_e        state, state_nx;
  logic [CNT_W-1:0] cnt;

  md_op_e           op_in;
  md_op_e           op_r;
  logic             neg_q;     // negate product / quotient in SIGN
  logic             neg_r;     // negate remainder in SIGN
  logic [WIDTH-1:0] opb;       // |multiplicand| or |divisor|
  logic [W2-1:0]    acc;

  logic             accept;
  logic             dz;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  logic [WIDTH+1:0] add_x, add_y, add_s;
  logic             add_cin;

  logic [W2-1:0]    prod_fix;

  assign op_in  = md_op_e'(op);
  assign accept = start && !cancel && ((state == IDLE) || (state == DONE));
  assign dz     = is_div(op_in) && (b == '0);
  assign a_neg  = is_signed_op(op_in) && a[WIDTH-1];
  assign b_neg  = is_signed_op(op_in) && b[WIDTH-1];
  assign a_abs  = cond_neg(a, a_neg);
  assign b_abs  = cond_neg(b, b_neg);

  assign busy   = (state == CALC) || (state == SIGN);

  // Next-state logic; cancel overrides everything.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: begin
        if (accept)              state_nx = dz ? DONE : CALC;
        else if (state == DONE)  state_nx = IDLE;
      end
      CALC: if (cnt == CNT_W'(WIDTH - 1)) state_nx = SIGN;
      SIGN: state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    if (cancel) state_nx = IDLE;
  end

  // Shared adder: add for multiply, subtract (x + ~y + 1) for divide.
  // The extra top bit is the borrow for the divide trial subtraction.
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;
    if (is_div(op_r)) begin
      add_x   = {1'b0, acc[W2-1:WIDTH-1]};
      add_y   = ~{2'b00, opb};
      add_cin = 1'b1;
    end else begin
      add_x   = {2'b00, acc[W2-1:WIDTH]};
      add_y   = acc[0] ? {2'b00, opb} : '0;
    end
    add_s = add_x + add_y + {{(WIDTH+1){1'b0}}, add_cin};
  end

  assign prod_fix = cond_neg2(acc, neg_q);

  // Control and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      valid       <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      state       <= state_nx;
      valid       <= 1'b0;
      div_by_zero <= 1'b0;
      if (accept) begin
        cnt <= '0;
        if (dz) begin
          hi          <= a;
          lo          <= '1;
          valid       <= 1'b1;
          div_by_zero <= 1'b1;
        end
      end else if ((state == CALC) && !cancel) begin
        cnt <= cnt + CNT_W'(1);
      end else if ((state == SIGN) && !cancel) begin
        valid <= 1'b1;
        if (is_div(op_r)) begin
          hi <= cond_neg(acc[W2-1:WIDTH], neg_r);
          lo <= cond_neg(acc[WIDTH-1:0], neg_q);
        end else begin
          hi <= prod_fix[W2-1:WIDTH];
          lo <= prod_fix[WIDTH-1:0];
        end
      end
    end
  end

  // Datapath registers (no reset; only meaningful after an accept)
  always_ff @(posedge clk) begin
    if (accept) begin
      op_r  <= op_in;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      opb   <= b_abs;
      acc   <= {{WIDTH{1'b0}}, a_abs};
    end else if (state == CALC) begin
      if (is_div(op_r)) begin
        if (add_s[WIDTH+1]) acc <= {acc[W2-2:0], 1'b0};
        else                acc <= {add_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc <= {add_s[WIDTH:0], acc[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Parametrised, iterative multiply/divide unit for the EX stage. It computes signed/unsigned products and quotient/remainder pairs over WIDTH-bit operands at one bit per cycle, and delivers a {hi, lo} result for the HI/LO register write. It replaces the combinational multiplier and the externally supplied divide result with a single start/busy/valid engine. The pipeline stalls on `busy` and flushes the engine through `cancel`.

## Interface
- `WIDTH`, default 32: operand width; must be even and ≥ 4.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `start`  in  1  request; sampled only when not busy.
- `op`  in  2  operation, encoded per `muldiv_pkg`: MULT, MULTU, DIV, DIVU.
- `a`  in  WIDTH  num1: multiplicand or dividend.
- `b`  in  WIDTH  num2: multiplier or divisor.
- `cancel`  in  1  flush (exception or branch kill); aborts the current operation.
- `busy`  out  1  high while an operation is in flight.
- `valid`  out  1  one-cycle pulse; `hi`/`lo` are valid.
- `hi`  out  WIDTH  product high half, or remainder.
- `lo`  out  WIDTH  product low half, or quotient.
- `div_by_zero`  out  1  qualifies `valid`; DIV/DIVU was issued with b == 0.

## Operation
- **States:** IDLE, CALC, SIGN, DONE.
- **Accept:**
  - `start` is accepted in IDLE or DONE when `cancel` is low.
  - Accepting latches `op`, the sign flags and the absolute operand values (signed ops only), and clears the step counter.
  - `start` in CALC or SIGN is ignored.
- **Multiply:**
  - Shift-add over the absolute operands, one multiplier bit per CALC cycle, into a 2·WIDTH accumulator.
  - SIGN negates the 2·WIDTH product iff op = MULT and a[W-1] ^ b[W-1].
- **Divide:**
  - Restoring division, one quotient bit per CALC cycle, over the absolute operands.
  - For DIV, SIGN negates the quotient iff the signs differ and negates the remainder iff the dividend is negative.
  - MIN / −1 yields lo = MIN, hi = 0, with no flag raised.
- **Divide by zero:**
  - Accepting DIV/DIVU with b == 0 goes directly to DONE.
  - Result is hi = a, lo = all ones, `div_by_zero` = 1.
- **Transitions:**
  - CALC runs exactly WIDTH cycles, then goes to SIGN.
  - SIGN writes `hi`/`lo` and goes to DONE.
  - DONE returns to IDLE, or re-enters CALC on an accepted `start`.
- **Cancel:**
  - Forces IDLE at the next edge from any state.
  - No `valid` is produced and `hi`/`lo` are unchanged.
  - Cancel wins over a simultaneous `start`.
- **Reset:**
  - Forces IDLE from any state, including mid-operation.
  - State after reset: `busy` = 0, `valid` = 0, `div_by_zero` = 0, `hi` = 0, `lo` = 0, counter = 0.
- **Hold:** `hi`/`lo` hold their last result until the next SIGN or divide-by-zero write.
- **Arithmetic:** all internal arithmetic is unsigned modulo 2^(2·WIDTH); absolute value of MIN is 2^(W-1).

## Timing
- Let `start` be accepted at edge k.
- **Normal operation:**
  - CALC occupies edges k+1 … k+WIDTH.
  - SIGN updates `hi`/`lo` at edge k+WIDTH+1.
  - `valid` is high for the cycle after edge k+WIDTH+1, i.e. a latency of WIDTH+2 (34 for WIDTH = 32).
- **Divide by zero:** `valid` and `div_by_zero` are high for the cycle after edge k (latency 1).
- **`busy`:**
  - High in CALC and SIGN, and in the cycle after an accepting edge that enters CALC.
  - Low in IDLE and DONE.
- **Back-to-back:** a `start` in the DONE (valid) cycle is accepted, giving a throughput of one operation per WIDTH+2 cycles.
- **Outputs:**
  - `valid` and `div_by_zero` are registered; `div_by_zero` is 0 whenever `valid` is 0.
  - No combinational path from inputs to outputs.

## Structure
- **`muldiv_pkg`:**
  - Op encodings: MD_MULT = 2'b00, MD_MULTU = 2'b01, MD_DIV = 2'b10, MD_DIVU = 2'b11.
  - State enum: IDLE, CALC, SIGN, DONE.
  - Shared by the decoder, the ALU control and this block.
- **Sub-modules:** none required; the datapath is a single 2·WIDTH shift register plus a WIDTH+1 adder/subtractor shared by both ops.
- **Counter width:** $clog2(WIDTH)+1.

## Test plan
1. MULT, a = 0xFFFFFFFE, b = 3 → at cycle 34: `valid`, hi = 0xFFFFFFFF, lo = 0xFFFFFFFA; MULTU with the same operands → hi = 0x00000002, lo = 0xFFFFFFFA.
2. DIV, a = −7, b = 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIVU, a = 0x80000000, b = 0xFFFFFFFF → lo = 0, hi = 0x80000000.
3. DIV, a = 0x80000000, b = 0xFFFFFFFF → lo = 0x80000000, hi = 0, `div_by_zero` = 0.
4. DIVU, a = 0x1234, b = 0 → `valid` and `div_by_zero` at cycle 1, hi = 0x1234, lo = 0xFFFFFFFF.
5. MULT started, `cancel` at cycle 10 → `busy` low from cycle 11, no `valid`, hi/lo keep the previous result; `start` and `cancel` in the same cycle → nothing accepted.
6. `rst` asserted at cycle 20 of a DIV → all outputs 0 next cycle; back-to-back `start` in a DONE cycle → second `valid` exactly 34 cycles later; `start` while busy is ignored.
